// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes, condition functions
// and the default datapath width.
package y86_pkg;

  localparam int unsigned WORD_W = 64;

  typedef enum logic [3:0] {
    NOP    = 4'h1,
    CMOVXX = 4'h2,
    OPQ    = 4'h6,
    JXX    = 4'h7
  } icode_e;

  typedef enum logic [2:0] {
    AOK = 3'd1,
    HLT = 3'd2,
    ADR = 3'd3,
    INS = 3'd4
  } stat_e;

  typedef enum logic [3:0] {
    C_YES = 4'h0,
    C_LE  = 4'h1,
    C_L   = 4'h2,
    C_E   = 4'h3,
    C_NE  = 4'h4,
    C_GE  = 4'h5,
    C_G   = 4'h6
  } cond_e;

  localparam logic [3:0] RNONE = 4'hF;

  function automatic logic stat_is_exc(input logic [2:0] s);
    return (s == ADR) || (s == INS) || (s == HLT);
  endfunction

endpackage

// File: rtl/exec_cc_unit_cond_eval.sv
// Combinational jXX/cmovXX condition evaluation against a ZF/SF/OF triple.
module cond_eval
  import y86_pkg::*;
(
  input  logic [3:0] ifun,
  input  logic       zf,
  input  logic       sf,
  input  logic       of,
  output logic       cnd
);

  logic lt;

  always_comb begin
    lt  = sf ^ of;
    cnd = 1'b0;
    case (ifun)
      C_YES:   cnd = 1'b1;
      C_LE:    cnd = lt | zf;
      C_L:     cnd = lt;
      C_E:     cnd = zf;
      C_NE:    cnd = ~zf;
      C_GE:    cnd = ~lt;
      C_G:     cnd = ~lt & ~zf;
      default: cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/exec_cc_unit.sv
// Execute-stage condition-code register, branch/cmov resolution and the
// E->M pipeline register for the Y86-64 pipeline.
module exec_cc_unit
  import y86_pkg::*;
#(
  parameter int unsigned WORD_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        E_icode,
  input  logic [3:0]        E_ifun,
  input  logic [2:0]        E_stat,
  input  logic [WORD_W-1:0] E_valA,
  input  logic [3:0]        E_dstE,
  input  logic [WORD_W-1:0] e_valE,
  input  logic              e_of,
  input  logic [2:0]        m_stat,
  input  logic [2:0]        W_stat,
  input  logic              M_bubble,
  output logic              cc_zf,
  output logic              cc_sf,
  output logic              cc_of,
  output logic              e_cnd,
  output logic [3:0]        e_dstE,
  output logic [3:0]        M_icode,
  output logic [2:0]        M_stat,
  output logic              M_cnd,
  output logic [WORD_W-1:0] M_valE,
  output logic [WORD_W-1:0] M_valA,
  output logic [3:0]        M_dstE,
  output logic              mispredict
);

  logic zf_q, sf_q, of_q;
  logic zf_d, sf_d, of_d;
  logic raw_cnd;
  logic set_cc;

  logic [3:0]        m_icode_q, m_icode_d;
  logic [2:0]        m_stat_q,  m_stat_d;
  logic              m_cnd_q,   m_cnd_d;
  logic [WORD_W-1:0] m_vale_q,  m_vale_d;
  logic [WORD_W-1:0] m_vala_q,  m_vala_d;
  logic [3:0]        m_dste_q,  m_dste_d;

  cond_eval u_cond_eval (
    .ifun (E_ifun),
    .zf   (zf_q),
    .sf   (sf_q),
    .of   (of_q),
    .cnd  (raw_cnd)
  );

  always_comb begin
    e_cnd  = ((E_icode == JXX) || (E_icode == CMOVXX)) && raw_cnd;
    e_dstE = ((E_icode == CMOVXX) && !e_cnd) ? RNONE : E_dstE;
    set_cc = (E_icode == OPQ) && !stat_is_exc(m_stat) && !stat_is_exc(W_stat);
  end

  // The CC ignores M_bubble: a bubbled OPq still commits its flags.
  always_comb begin
    zf_d = zf_q;
    sf_d = sf_q;
    of_d = of_q;
    if (set_cc) begin
      zf_d = (e_valE == '0);
      sf_d = e_valE[WORD_W-1];
      of_d = e_of;
    end
  end

  always_comb begin
    m_icode_d = E_icode;
    m_stat_d  = E_stat;
    m_cnd_d   = e_cnd;
    m_vale_d  = e_valE;
    m_vala_d  = E_valA;
    m_dste_d  = e_dstE;
    if (M_bubble) begin
      m_icode_d = NOP;
      m_stat_d  = AOK;
      m_cnd_d   = 1'b0;
      m_vale_d  = '0;
      m_vala_d  = '0;
      m_dste_d  = RNONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zf_q      <= 1'b1;
      sf_q      <= 1'b0;
      of_q      <= 1'b0;
      m_icode_q <= NOP;
      m_stat_q  <= AOK;
      m_cnd_q   <= 1'b0;
      m_vale_q  <= '0;
      m_vala_q  <= '0;
      m_dste_q  <= RNONE;
    end else begin
      zf_q      <= zf_d;
      sf_q      <= sf_d;
      of_q      <= of_d;
      m_icode_q <= m_icode_d;
      m_stat_q  <= m_stat_d;
      m_cnd_q   <= m_cnd_d;
      m_vale_q  <= m_vale_d;
      m_vala_q  <= m_vala_d;
      m_dste_q  <= m_dste_d;
    end
  end

  assign cc_zf      = zf_q;
  assign cc_sf      = sf_q;
  assign cc_of      = of_q;
  assign M_icode    = m_icode_q;
  assign M_stat     = m_stat_q;
  assign M_cnd      = m_cnd_q;
  assign M_valE     = m_vale_q;
  assign M_valA     = m_vala_q;
  assign M_dstE     = m_dste_q;
  assign mispredict = (m_icode_q == JXX) && !m_cnd_q;

endmodule

// File: tb/tb_exec_cc_unit.sv
// Scoreboard bench for exec_cc_unit: stimulus queues cycle-tagged expectations,
// a negedge monitor compares every entry due in the current cycle.
module tb_exec_cc_unit;

  localparam int unsigned W = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    E_icode, E_ifun, E_dstE;
  logic [2:0]    E_stat, m_stat, W_stat;
  logic [W-1:0]  E_valA, e_valE;
  logic          e_of, M_bubble;
  logic          cc_zf, cc_sf, cc_of, e_cnd, M_cnd, mispredict;
  logic [3:0]    e_dstE, M_icode, M_dstE;
  logic [2:0]    M_stat;
  logic [W-1:0]  M_valE, M_valA;

  exec_cc_unit #(.WORD_W(W)) dut (
    .clk(clk), .rst(rst),
    .E_icode(E_icode), .E_ifun(E_ifun), .E_stat(E_stat), .E_valA(E_valA),
    .E_dstE(E_dstE), .e_valE(e_valE), .e_of(e_of),
    .m_stat(m_stat), .W_stat(W_stat), .M_bubble(M_bubble),
    .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of),
    .e_cnd(e_cnd), .e_dstE(e_dstE),
    .M_icode(M_icode), .M_stat(M_stat), .M_cnd(M_cnd),
    .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE),
    .mispredict(mispredict)
  );

  always #5 clk = ~clk;

  typedef enum int {
    F_ZF, F_SF, F_OF, F_CND, F_DSTE, F_MICODE, F_MSTAT,
    F_MCND, F_MVALE, F_MVALA, F_MDSTE, F_MISP
  } field_e;

  typedef struct {
    int unsigned cyc;
    string       name;
    field_e      fld;
    logic [63:0] exp;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] actual(input field_e f);
    case (f)
      F_ZF:     return 64'(cc_zf);
      F_SF:     return 64'(cc_sf);
      F_OF:     return 64'(cc_of);
      F_CND:    return 64'(e_cnd);
      F_DSTE:   return 64'(e_dstE);
      F_MICODE: return 64'(M_icode);
      F_MSTAT:  return 64'(M_stat);
      F_MCND:   return 64'(M_cnd);
      F_MVALE:  return 64'(M_valE);
      F_MVALA:  return 64'(M_valA);
      F_MDSTE:  return 64'(M_dstE);
      default:  return 64'(mispredict);
    endcase
  endfunction

  // Monitor: pops every expectation due this cycle; stale ones count as failures.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        logic [63:0] a;
        a = actual(sb[i].fld);
        checks++;
        if (sb[i].cyc < cyc) begin
          errors++;
          $display("FAIL %s: expectation for cycle %0d missed (now %0d)", sb[i].name, sb[i].cyc, cyc);
        end else if (a !== sb[i].exp) begin
          errors++;
          $display("FAIL %s: got %0h expected %0h (cycle %0d)", sb[i].name, a, sb[i].exp, cyc);
        end
        sb.delete(i);
      end
    end
  end

  task automatic expect_at(input int unsigned ofs, input string name, input field_e f,
                           input logic [63:0] v);
    exp_t e;
    e.cyc = cyc + ofs; e.name = name; e.fld = f; e.exp = v;
    sb.push_back(e);
  endtask

  // Drive one Execute-stage cycle just after the rising edge.
  task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [2:0] st,
                       input logic [63:0] va, input logic [3:0] de, input logic [63:0] ve,
                       input logic of, input logic [2:0] ms, input logic [2:0] ws,
                       input logic bub, input logic r);
    @(posedge clk);
    #1;
    E_icode = ic; E_ifun = fn; E_stat = st; E_valA = va; E_dstE = de;
    e_valE = ve; e_of = of; m_stat = ms; W_stat = ws; M_bubble = bub; rst = r;
  endtask

  initial begin
    rst = 1'b1;
    E_icode = 4'h1; E_ifun = 4'h0; E_stat = 3'd1; E_valA = '0; E_dstE = 4'hF;
    e_valE = '0; e_of = 1'b0; m_stat = 3'd1; W_stat = 3'd1; M_bubble = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    expect_at(0, "rst_zf", F_ZF, 64'd1);
    expect_at(0, "rst_sf", F_SF, 64'd0);
    expect_at(0, "rst_of", F_OF, 64'd0);
    expect_at(0, "rst_micode", F_MICODE, 64'h1);
    expect_at(0, "rst_mstat", F_MSTAT, 64'h1);
    expect_at(0, "rst_mdste", F_MDSTE, 64'hF);
    expect_at(0, "rst_misp", F_MISP, 64'd0);

    // subq equal then je
    drive(4'h6, 4'h1, 3'd1, 64'h11, 4'h2, 64'h0, 1'b0, 3'd1, 3'd1, 1'b0, 1'b0);
    expect_at(0, "opq_cnd", F_CND, 64'd0);
    expect_at(1, "eq_zf", F_ZF, 64'd1);
    expect_at(1, "eq_micode", F_MICODE, 64'h6);
    expect_at(1, "eq_mvale", F_MVALE, 64'h0);
    expect_at(1, "eq_mdste", F_MDSTE, 64'h2);
    drive(4'h7, 4'h3, 3'd1, 64'h100, 4'hF, 64'h0, 1'b0, 3'd1, 3'd1, 1'b0, 1'b0);
    expect_at(0, "je_cnd", F_CND, 64'd1);
    expect_at(1, "je_mcnd", F_MCND, 64'd1);
    expect_at(1, "je_mvala", F_MVALA, 64'h100);
    expect_at(1, "je_misp", F_MISP, 64'd0);

    // signed overflow
    drive(4'h6, 4'h0, 3'd1, 64'h0, 4'h4, 64'h8000_0000_0000_0000, 1'b1, 3'd1, 3'd1, 1'b0, 1'b0);
    expect_at(1, "ovf_zf", F_ZF, 64'd0);
    expect_at(1, "ovf_sf", F_SF, 64'd1);
    expect_at(1, "ovf_of", F_OF, 64'd1);
    drive(4'h7, 4'h2, 3'd1, 64'h200, 4'hF, 64'h0, 1'b0, 3'd1, 3'd1, 1'b0, 1'b0);
    expect_at(0, "jl_cnd", F_CND, 64'd0);
    expect_at(1, "jl_mcnd", F_MCND, 64'd0);
    expect_at(1, "jl_misp", F_MISP, 64'd1);
    drive(4'h7, 4'h5, 3'd1, 64'h300, 4'hF, 64'h0, 1'b0, 3'd1, 3'd1, 1'b0, 1'b0);
    expect_at(0, "jge_cnd", F_CND, 64'd1);
    expect_at(1, "jge_misp", F_MISP, 64'd0);

    // cmov with ZF=0
    drive(4'h2, 4'h3, 3'd1, 64'h5, 4'h3, 64'h5, 1'b0, 3'd1, 3'd1, 1'b0, 1'b0);
    expect_at(0, "cmove_cnd", F_CND, 64'd0);
    expect_at(0, "cmove_dste", F_DSTE, 64'hF);
    expect_at(1, "cmove_mdste", F_MDSTE, 64'hF);
    drive(4'h2, 4'h4, 3'd1, 64'h5, 4'h3, 64'h5, 1'b0, 3'd1, 3'd1, 1'b0, 1'b0);
    expect_at(0, "cmovne_cnd", F_CND, 64'd1);
    expect_at(0, "cmovne_dste", F_DSTE, 64'h3);
    expect_at(1, "cmovne_mdste", F_MDSTE, 64'h3);

    // exception suppression
    drive(4'h6, 4'h0, 3'd1, 64'h0, 4'h1, 64'h0, 1'b0, 3'd1, 3'd3, 1'b0, 1'b0);
    expect_at(1, "wadr_zf", F_ZF, 64'd0);
    expect_at(1, "wadr_micode", F_MICODE, 64'h6);
    drive(4'h6, 4'h0, 3'd1, 64'h0, 4'h1, 64'h0, 1'b0, 3'd4, 3'd1, 1'b0, 1'b0);
    expect_at(1, "mins_zf", F_ZF, 64'd0);
    drive(4'h6, 4'h0, 3'd1, 64'h0, 4'h1, 64'h0, 1'b0, 3'd2, 3'd1, 1'b0, 1'b0);
    expect_at(1, "mhlt_zf", F_ZF, 64'd0);
    drive(4'h6, 4'h0, 3'd1, 64'h0, 4'h1, 64'h0, 1'b0, 3'd1, 3'd1, 1'b0, 1'b0);
    expect_at(1, "aok_zf", F_ZF, 64'd1);

    // bubble does not block CC
    drive(4'h6, 4'h0, 3'd2, 64'h9, 4'h5, 64'h5, 1'b0, 3'd1, 3'd1, 1'b1, 1'b0);
    expect_at(1, "bub_zf", F_ZF, 64'd0);
    expect_at(1, "bub_sf", F_SF, 64'd0);
    expect_at(1, "bub_micode", F_MICODE, 64'h1);
    expect_at(1, "bub_mvale", F_MVALE, 64'h0);
    expect_at(1, "bub_mvala", F_MVALA, 64'h0);
    expect_at(1, "bub_mstat", F_MSTAT, 64'h1);
    expect_at(1, "bub_mdste", F_MDSTE, 64'hF);

    // negative result: SF=1, OF=0, ZF=0
    drive(4'h6, 4'h1, 3'd1, 64'h0, 4'h6, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3'd1, 3'd1, 1'b0, 1'b0);
    expect_at(1, "neg_sf", F_SF, 64'd1);
    expect_at(1, "neg_of", F_OF, 64'd0);
    drive(4'h7, 4'h1, 3'd1, 64'h0, 4'hF, 64'h0, 1'b0, 3'd1, 3'd1, 1'b0, 1'b0);
    expect_at(0, "jle_cnd", F_CND, 64'd1);
    drive(4'h7, 4'h6, 3'd1, 64'h0, 4'hF, 64'h0, 1'b0, 3'd1, 3'd1, 1'b0, 1'b0);
    expect_at(0, "jg_cnd", F_CND, 64'd0);
    expect_at(1, "jg_misp", F_MISP, 64'd1);
    drive(4'h7, 4'h8, 3'd1, 64'h0, 4'hF, 64'h0, 1'b0, 3'd1, 3'd1, 1'b0, 1'b0);
    expect_at(0, "jbad_cnd", F_CND, 64'd0);
    drive(4'h7, 4'h0, 3'd1, 64'h0, 4'hF, 64'h0, 1'b0, 3'd1, 3'd1, 1'b0, 1'b0);
    expect_at(0, "jmp_cnd", F_CND, 64'd1);
    drive(4'h1, 4'h0, 3'd2, 64'h7, 4'h8, 64'h7, 1'b0, 3'd1, 3'd1, 1'b0, 1'b0);
    expect_at(0, "nop_cnd", F_CND, 64'd0);
    expect_at(1, "hlt_mstat", F_MSTAT, 64'h2);

    // reset with bubble and a pending flag update
    drive(4'h6, 4'h0, 3'd1, 64'h1, 4'h2, 64'h8000_0000_0000_0000, 1'b1, 3'd1, 3'd1, 1'b1, 1'b1);
    expect_at(1, "rstb_zf", F_ZF, 64'd1);
    expect_at(1, "rstb_sf", F_SF, 64'd0);
    expect_at(1, "rstb_of", F_OF, 64'd0);
    expect_at(1, "rstb_micode", F_MICODE, 64'h1);
    expect_at(1, "rstb_mdste", F_MDSTE, 64'hF);
    drive(4'h1, 4'h0, 3'd1, 64'h0, 4'hF, 64'h0, 1'b0, 3'd1, 3'd1, 1'b0, 1'b0);

    // bounded drain of the scoreboard
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_cc_unit.md
# exec_cc_unit

Execute-stage condition-code and branch-resolution block for the Y86-64 pipeline. It consumes the ALU's 64-bit result and overflow flag, holds the ZF/SF/OF condition-code register, and evaluates jXX/cmovXX conditions against it. It also owns the E→M pipeline register, carrying cnd, valE, valA, dstE, icode and stat into the memory stage. It reports branch mispredicts to the fetch/PC-select logic.

## Interface
- `WORD_W`, default 64: datapath width; must match the ALU.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `E_icode`  in  4  instruction code in Execute.
- `E_ifun`  in  4  function code in Execute.
- `E_stat`  in  3  status of the Execute instruction.
- `E_valA`  in  WORD_W  forwarded valA; jXX fall-through PC for jXX.
- `E_dstE`  in  4  destination register for valE.
- `e_valE`  in  WORD_W  ALU result (`sum`).
- `e_of`  in  1  ALU overflow (`carry`); valid only for add/sub.
- `m_stat`  in  3  status leaving Memory this cycle.
- `W_stat`  in  3  status in Writeback.
- `M_bubble`  in  1  load a bubble into the M register.
- `cc_zf`, `cc_sf`, `cc_of`  out  1 each  current condition codes.
- `e_cnd`  out  1  combinational condition result for the Execute instruction.
- `e_dstE`  out  4  E_dstE, or RNONE for a not-taken cmov.
- `M_icode`  out  4  registered icode.
- `M_stat`  out  3  registered stat.
- `M_cnd`  out  1  registered cnd.
- `M_valE`  out  WORD_W  registered result.
- `M_valA`  out  WORD_W  registered valA.
- `M_dstE`  out  4  registered dstE.
- `mispredict`  out  1  combinational; M_icode==JXX && !M_cnd.

## Operation
- Condition evaluation from the current CC, before any update this cycle; x = SF^OF:
  - ifun 0: 1.
  - ifun 1 (le): x|ZF.
  - ifun 2 (l): x.
  - ifun 3 (e): ZF.
  - ifun 4 (ne): !ZF.
  - ifun 5 (ge): !x.
  - ifun 6 (g): !x&&!ZF.
  - ifun 7–15: 0.
- e_cnd applies only for icode JXX (7) or CMOVXX (2); otherwise e_cnd=0.
- e_dstE = RNONE (4'hF) when icode==CMOVXX && !e_cnd; otherwise E_dstE.
- set_cc = (E_icode==OPQ (6)) && m_stat ∉ {ADR,INS,HLT} && W_stat ∉ {ADR,INS,HLT}.
- On set_cc:
  - ZF ← (e_valE==0).
  - SF ← e_valE[WORD_W-1].
  - OF ← e_of.
- OF is taken from the ALU flag as delivered; it is not recomputed. xor/and produce e_of=0.
- The Y86 subq result is valB−valA; the ALU operand ordering is the decoder's concern, not this block's.
- M register per clock, in priority order:
  1. rst: M_icode=NOP (1), M_stat=AOK (1), M_cnd=0, M_valE=0, M_valA=0, M_dstE=RNONE.
  2. M_bubble: load the same values as reset.
  3. Otherwise: M_* ← E_icode, E_stat, e_cnd, e_valE, E_valA, e_dstE.
- M_bubble does not block a CC update; only set_cc governs the CC.

## Timing
- Reset values: ZF=1, SF=0, OF=0; M register values as listed under Operation.
- Because set_cc is gated only by set_cc, the CC updates on any clock edge with set_cc=1, including one where M_bubble=1.
- Latency:
  - e_cnd and e_dstE: 0 cycles (combinational).
  - CC: 1 cycle; visible the cycle after the OPq instruction.
  - M outputs: 1 cycle.
- Back-to-back OPq followed by jXX: the jXX evaluates against the OPq flags, which were written at the edge ending the OPq's Execute cycle.
- OPq and cmov/jXX are never both in Execute in the same cycle, so there is no read/write conflict on the CC.
- Exception in flight: an OPq in Execute while m_stat or W_stat ∈ {ADR,INS,HLT} leaves the CC unchanged. The OPq still passes to M unless bubbled.
- rst asserted mid-stream: the next edge yields reset values regardless of set_cc or M_bubble.
- mispredict depends only on registered state; it is glitch-free relative to E-stage inputs.

## Structure
- Shared package `y86_pkg`:
  - icode constants: NOP=1, CMOVXX=2, OPQ=6, JXX=7.
  - stat constants: AOK=1, HLT=2, ADR=3, INS=4.
  - RNONE=4'hF.
  - ifun condition codes.
  - WORD_W.
- Sub-module `cond_eval`: purely combinational; (ifun, zf, sf, of) → cnd. It is reused by the sequential reference model.

## Test plan
- Reset check: assert rst for 2 cycles → ZF=1, SF=0, OF=0, M_icode=1, M_dstE=F, mispredict=0.
- subq equal: OPq with e_valE=0, e_of=0, then jXX ifun 3 → ZF=1; e_cnd=1; the next cycle M_cnd=1 and mispredict=0.
- Signed overflow:
  - OPq with e_valE=64'h8000_0000_0000_0000, e_of=1 → SF=1, OF=1.
  - jXX ifun 2 (l) → e_cnd=0 and mispredict=1 one cycle later.
  - jXX ifun 5 (ge) → e_cnd=1.
- cmov not taken: CC ZF=0, CMOVXX ifun 3, E_dstE=3 → e_dstE=F and M_dstE=F next cycle. With ifun 4, e_dstE=3.
- Exception suppression: OPq with e_valE=0 while W_stat=ADR → CC unchanged (ZF stays 0). Repeat with m_stat=INS → unchanged. With stat=AOK → ZF=1.
- Bubble vs reset: M_bubble with a valid OPq in Execute → M_icode=NOP and M_valE=0, but the CC still updates. Assert rst and M_bubble together → reset values.
